seg_capture_decoder: RTL and testbench
======================================

# seg_capture_decoder

Receive-side counterpart of the nibble-to-seven-segment display path. It samples a time-multiplexed seven-segment bus that carries three digit positions: LSB, MSB and TYPE. It requires each glyph to be stable before accepting it, then reconstructs the original 4-bit value and display mode from the three glyphs. The result is presented with a valid/ready handshake, which lets a bench or downstream logic check the display chain end to end.

## Interface
- STABLE, 4: consecutive identical cycles required to accept a glyph (≥1).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment pattern; bit0=a … bit6=g; polarity per Configuration.
- dig_sel  input  3  one-hot strobe: bit0=LSB, bit1=MSB, bit2=TYPE.
- ready  input  1  consumer accepts result.
- valid  output  1  result available.
- value  output  4  reconstructed nibble.
- mode  output  1  0=hex, 1=decimal.
- err  output  1  result invalid (value forced 0).

## Operation
- Segment patterns below are internal and active-high (gfedcba).
  - Hex glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Blank=00, H=76.
- States:
  - SCAN: collect glyphs.
  - OUT: hold the result.
- Stability counter (saturating, width $clog2(STABLE+1)):
  - Increments while {dig_sel, seg_in} equals the previous cycle's value and dig_sel is one-hot.
  - Otherwise it reloads to 1 if dig_sel is one-hot, and to 0 if it is not.
- Capture (SCAN only): when the count reaches STABLE, the pattern is stored in the selected slot and the slot flag is set.
  - A captured pattern is stored once per stable run, not re-captured while the pattern stays held.
  - Re-capturing an already-filled slot overwrites it; the latest glyph wins.
- dig_sel zero or multi-hot: nothing is captured and the counter clears.
- When all three flags become set, the result is decoded and the FSM enters OUT with valid=1.
- Decode rules:
  - TYPE=H: hex mode; MSB must be blank; value = LSB glyph 0–F.
  - TYPE=d: decimal mode; MSB is blank (tens=0) or '1' (tens=1); LSB must be 0–9; value = tens*10 + units and must be ≤15.
  - Any other TYPE, an illegal glyph in any slot, or a decimal result >15 gives err=1 and value=0; mode still reflects TYPE (0 if TYPE is illegal).
- OUT:
  - Inputs are ignored; value, mode, err and valid are held.
  - On valid&&ready: flags and counter clear, valid drops, return to SCAN.

## Timing
- Reset values: valid=0, value=0, mode=0, err=0, flags clear, counter 0, state SCAN.
- rst asserted at any point (mid-scan or in OUT) clears everything at that edge; partial captures are discarded.
- Glyph acceptance: a pattern first presented in cycle k is captured at the end of cycle k+STABLE-1.
- The capture edge that completes the third slot also registers the outputs, so valid is high in the following cycle. No extra decode cycle.
- Handshake:
  - valid stays high until sampled with ready=1.
  - valid falls the cycle after the handshake.
  - ready while valid=0 has no effect.
- Collection restarts from SCAN; the first capture after a handshake takes at least STABLE cycles.
- A pattern held unchanged across the handshake counts from the SCAN re-entry cycle.

## Configuration
- SEG_CAPTURE_ACTIVE_LOW_EN:
  - Defined: seg_in is active-low (board convention) and is inverted on entry, before stability compare and decode.
  - Undefined: seg_in is used as-is (active-high).
- All test-plan values are the internal active-high patterns; the bench drives their complements when the macro is defined.

## Test plan
1. STABLE=4. Drive TYPE=76, LSB=7C, MSB=00, each held 4 cycles -> valid=1, value=0xB, mode=0, err=0.
2. Drive MSB=06, LSB=6D, TYPE=5E -> value=15, mode=1, err=0. Then ready=1 for one cycle -> valid=0 next cycle.
3. Drive MSB=06, LSB=7D, TYPE=5E (decimal 16) -> valid=1, err=1, value=0, mode=1.
4. Hold an LSB pattern 3 cycles and change it on the 4th; dig_sel=3'b011 for 10 cycles -> no capture; valid stays 0 after TYPE and MSB are supplied.
5. Reach valid, hold ready=0 for 10 cycles while seg_in toggles -> outputs unchanged. Then ready=1 -> valid=0 and a new scan completes correctly.
6. Capture LSB and MSB, assert rst one cycle, then supply only TYPE -> valid remains 0. All outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/seg_capture_decoder_if.sv
// seg_capture_decoder_if
// Bundles the multiplexed seven-segment bus and the result handshake of the
// seven-segment capture decoder.
//   seg_in  [6:0] segment pattern, bit0=a .. bit6=g (polarity set in the decoder)
//   dig_sel [2:0] one-hot digit strobe: bit0=LSB, bit1=MSB, bit2=TYPE
//   ready         consumer accepts the current result
//   valid         result available
//   value   [3:0] reconstructed nibble
//   mode          0=hex, 1=decimal
//   err           result invalid (value forced to 0)
// master: drives the bus and ready, observes the result.
// slave : the decoder itself.
interface seg_capture_decoder_if;
  logic [6:0] seg_in;
  logic [2:0] dig_sel;
  logic       ready;
  logic       valid;
  logic [3:0] value;
  logic       mode;
  logic       err;

  modport master (output seg_in, dig_sel, ready,
                  input  valid, value, mode, err);
  modport slave  (input  seg_in, dig_sel, ready,
                  output valid, value, mode, err);
endinterface

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder
// Samples a time-multiplexed seven-segment bus carrying LSB, MSB and TYPE
// glyphs. It accepts each glyph once it has been stable for STABLE cycles,
// then rebuilds the 4-bit value and display mode and offers the result on a
// valid/ready handshake.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seg_capture_decoder_if.slave (seg_in, dig_sel, ready in;
//        valid, value, mode, err out)
// Parameter:
//   STABLE  consecutive identical cycles needed to accept a glyph (>=1)
// Build option:
//   SEG_CAPTURE_ACTIVE_LOW_EN  when defined, seg_in is active-low and is
//                              inverted on entry; otherwise it is used as-is.
module seg_capture_decoder #(
  parameter int STABLE = 4
) (
  input logic                  clk,
  input logic                  rst,
  seg_capture_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  typedef enum logic {SCAN, OUT} state_t;

  state_t r_state, w_stateNext;

  logic [2:0]    r_prevSel;
  logic [6:0]    r_prevSeg;
  logic [CW-1:0] r_count;
  logic [2:0]    r_flags;
  logic [6:0]    r_slotLsb, r_slotMsb, r_slotType;
  logic          r_valid, r_mode, r_err;
  logic [3:0]    r_value;

  logic [6:0]    w_seg;
  logic          w_oneHot, w_same, w_capture, w_done, w_handshake;
  logic [CW-1:0] w_countNext;
  logic [2:0]    w_flagsNext;
  logic [6:0]    w_lsbNext, w_msbNext, w_typeNext;
  logic [4:0]    w_lsbHex;
  logic [4:0]    w_decSum;
  logic          w_tensOk, w_tens;
  logic          w_decMode, w_decErr;
  logic [3:0]    w_decValue;

  // Everything downstream works on active-high patterns.
`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
  assign w_seg = ~bus.seg_in;
`else
  assign w_seg = bus.seg_in;
`endif

  // Maps a glyph to {legal, hex digit}; anything not in the table is illegal.
  function automatic logic [4:0] glyphToHex(input logic [6:0] g);
    case (g)
      7'h3F: return 5'h10;
      7'h06: return 5'h11;
      7'h5B: return 5'h12;
      7'h4F: return 5'h13;
      7'h66: return 5'h14;
      7'h6D: return 5'h15;
      7'h7D: return 5'h16;
      7'h07: return 5'h17;
      7'h7F: return 5'h18;
      7'h6F: return 5'h19;
      7'h77: return 5'h1A;
      7'h7C: return 5'h1B;
      7'h39: return 5'h1C;
      7'h5E: return 5'h1D;
      7'h79: return 5'h1E;
      7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign w_oneHot    = (bus.dig_sel == 3'b001) || (bus.dig_sel == 3'b010) ||
                       (bus.dig_sel == 3'b100);
  assign w_same      = w_oneHot && ({bus.dig_sel, w_seg} == {r_prevSel, r_prevSeg});
  assign w_handshake = (r_state == OUT) && r_valid && bus.ready;

  // Saturating run counter: reloads to 1 on a new one-hot pattern, 0 when the
  // strobe is not one-hot.
  always_comb begin
    w_countNext = '0;
    if (w_same) begin
      w_countNext = (r_count == STABLE_C) ? r_count : r_count + 1'b1;
    end else if (w_oneHot) begin
      w_countNext = CW'(1);
    end
  end

  // A run that was already saturated last cycle has been captured, so only the
  // cycle the count first reaches STABLE stores the glyph.
  assign w_capture   = (r_state == SCAN) && w_oneHot && (w_countNext == STABLE_C) &&
                       !(w_same && (r_count == STABLE_C));
  assign w_flagsNext = r_flags | (w_capture ? bus.dig_sel : 3'b000);
  assign w_lsbNext   = (w_capture && bus.dig_sel[0]) ? w_seg : r_slotLsb;
  assign w_msbNext   = (w_capture && bus.dig_sel[1]) ? w_seg : r_slotMsb;
  assign w_typeNext  = (w_capture && bus.dig_sel[2]) ? w_seg : r_slotType;
  assign w_done      = (r_state == SCAN) && (&w_flagsNext);

  // Decode works on the slot contents as they will be after this edge, so the
  // completing capture also registers the result.
  assign w_lsbHex = glyphToHex(w_lsbNext);
  assign w_tensOk = (w_msbNext == 7'h00) || (w_msbNext == 7'h06);
  assign w_tens   = (w_msbNext == 7'h06);
  assign w_decSum = (w_tens ? 5'd10 : 5'd0) + {1'b0, w_lsbHex[3:0]};

  always_comb begin
    w_decMode  = 1'b0;
    w_decErr   = 1'b1;
    w_decValue = 4'h0;
    if (w_typeNext == 7'h76) begin
      if ((w_msbNext == 7'h00) && w_lsbHex[4]) begin
        w_decErr   = 1'b0;
        w_decValue = w_lsbHex[3:0];
      end
    end else if (w_typeNext == 7'h5E) begin
      w_decMode = 1'b1;
      if (w_tensOk && w_lsbHex[4] && (w_lsbHex[3:0] <= 4'd9) && (w_decSum <= 5'd15)) begin
        w_decErr   = 1'b0;
        w_decValue = w_decSum[3:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= SCAN;
    else     r_state <= w_stateNext;
  end

  // Next-state: scan until all three slots are filled, hold until handshake.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      SCAN:    if (w_done)      w_stateNext = OUT;
      OUT:     if (w_handshake) w_stateNext = SCAN;
      default: w_stateNext = SCAN;
    endcase
  end

  // Datapath. The previous-input registers keep tracking during OUT so that a
  // pattern held across the handshake counts from the SCAN re-entry cycle
  // with the counter starting from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevSel  <= '0;
      r_prevSeg  <= '0;
      r_count    <= '0;
      r_flags    <= '0;
      r_slotLsb  <= '0;
      r_slotMsb  <= '0;
      r_slotType <= '0;
      r_valid    <= 1'b0;
      r_value    <= '0;
      r_mode     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prevSel <= bus.dig_sel;
      r_prevSeg <= w_seg;
      if (r_state == SCAN) begin
        r_count    <= w_countNext;
        r_flags    <= w_flagsNext;
        r_slotLsb  <= w_lsbNext;
        r_slotMsb  <= w_msbNext;
        r_slotType <= w_typeNext;
        if (w_done) begin
          r_valid <= 1'b1;
          r_value <= w_decValue;
          r_mode  <= w_decMode;
          r_err   <= w_decErr;
        end
      end else begin
        r_count <= '0;
        if (w_handshake) begin
          r_flags <= '0;
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.valid = r_valid;
  assign bus.value = r_value;
  assign bus.mode  = r_mode;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// tb_seg_capture_decoder
// Drives the capture decoder with directed scenarios followed by randomized
// glyph traffic and compares every output on every cycle with a behavioural
// model built from the glyph-acceptance and decode rules.
module tb_seg_capture_decoder;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst;

  seg_capture_decoder_if bus();

  seg_capture_decoder #(.STABLE(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  logic [6:0] glyphTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state.
  int         runLen;
  logic [2:0] mPrevSel;
  logic [6:0] mPrevSeg;
  logic [6:0] mSlot [3];
  bit         mFilled [3];
  bit         holding;
  logic       expValid, expMode, expErr;
  logic [3:0] expValue;

  // Single comparison point: counts the vector and reports any difference.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int glyphIndex(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (glyphTable[i] == g) return i;
    return -1;
  endfunction

  function automatic logic [6:0] toBus(input logic [6:0] seg);
`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
    return ~seg;
`else
    return seg;
`endif
  endfunction

  // Rebuild value/mode/err from the three stored glyphs with plain arithmetic.
  task automatic modelDecode();
    int units, tens, total;
    units    = glyphIndex(mSlot[0]);
    expErr   = 1'b1;
    expValue = 4'h0;
    expMode  = 1'b0;
    if (mSlot[2] == 7'h76) begin
      if (mSlot[1] == 7'h00 && units >= 0) begin
        expErr   = 1'b0;
        expValue = 4'(units);
      end
    end else if (mSlot[2] == 7'h5E) begin
      expMode = 1'b1;
      tens = (mSlot[1] == 7'h00) ? 0 : (mSlot[1] == 7'h06) ? 1 : -1;
      if (tens >= 0 && units >= 0 && units <= 9) begin
        total = tens * 10 + units;
        if (total <= 15) begin
          expErr   = 1'b0;
          expValue = 4'(total);
        end
      end
    end
  endtask

  // One clock edge of the model, given the inputs present before that edge.
  task automatic modelStep(input logic [2:0] sel, input logic [6:0] seg, input logic rdy, input logic rstv);
    bit oneHot;
    int idx;
    if (rstv) begin
      runLen   = 0;
      mPrevSel = '0;
      mPrevSeg = '0;
      for (int i = 0; i < 3; i++) begin mSlot[i] = '0; mFilled[i] = 0; end
      holding  = 0;
      expValid = 0; expValue = 0; expMode = 0; expErr = 0;
      return;
    end
    if (holding) begin
      runLen = 0;
      if (rdy) begin
        holding  = 0;
        expValid = 0;
        for (int i = 0; i < 3; i++) mFilled[i] = 0;
      end
    end else begin
      oneHot = ($countones(sel) == 1);
      if (oneHot && sel == mPrevSel && seg == mPrevSeg) runLen++;
      else runLen = oneHot ? 1 : 0;
      if (runLen == STABLE) begin
        idx = sel[0] ? 0 : (sel[1] ? 1 : 2);
        mSlot[idx]   = seg;
        mFilled[idx] = 1;
      end
      if (mFilled[0] && mFilled[1] && mFilled[2]) begin
        modelDecode();
        holding  = 1;
        expValid = 1;
      end
    end
    mPrevSel = sel;
    mPrevSeg = seg;
  endtask

  // One cycle: drive at the falling edge, step the model at the rising edge,
  // compare at the next falling edge.
  task automatic applyStimulus(input logic [2:0] sel, input logic [6:0] seg, input logic rdy, input logic rstv);
    bus.dig_sel = sel;
    bus.seg_in  = toBus(seg);
    bus.ready   = rdy;
    rst         = rstv;
    @(posedge clk);
    modelStep(sel, seg, rdy, rstv);
    @(negedge clk);
    checkOutput("valid", {7'b0, bus.valid}, {7'b0, expValid});
    checkOutput("value", {4'b0, bus.value}, {4'b0, expValue});
    checkOutput("mode",  {7'b0, bus.mode},  {7'b0, expMode});
    checkOutput("err",   {7'b0, bus.err},   {7'b0, expErr});
  endtask

  task automatic present(input logic [2:0] sel, input logic [6:0] seg, input int n);
    repeat (n) applyStimulus(sel, seg, 1'b0, 1'b0);
  endtask

  task automatic handshake();
    applyStimulus(3'b000, 7'h00, 1'b1, 1'b0);
  endtask

  task automatic checkResult(input string tag, input logic v, input logic [3:0] val,
                             input logic m, input logic e);
    checkOutput({tag, "_valid"}, {7'b0, bus.valid}, {7'b0, v});
    checkOutput({tag, "_value"}, {4'b0, bus.value}, {4'b0, val});
    checkOutput({tag, "_mode"},  {7'b0, bus.mode},  {7'b0, m});
    checkOutput({tag, "_err"},   {7'b0, bus.err},   {7'b0, e});
  endtask

  function automatic logic [6:0] randGlyph(input logic [2:0] sel);
    int pick;
    pick = $urandom_range(0, 9);
    if (pick == 0) return 7'($urandom);
    if (sel == 3'b100) return (pick < 5) ? 7'h76 : (pick < 9) ? 7'h5E : 7'h00;
    if (sel == 3'b010) return (pick < 5) ? 7'h00 : (pick < 9) ? 7'h06 : 7'h3F;
    return glyphTable[$urandom_range(0, 15)];
  endfunction

  initial begin
    logic [2:0] sel;
    logic [6:0] seg;
    int         len;

    applyStimulus(3'b000, 7'h00, 1'b0, 1'b1);
    applyStimulus(3'b000, 7'h00, 1'b0, 1'b1);
    checkResult("reset", 1'b0, 4'h0, 1'b0, 1'b0);

    // Hex b.
    present(3'b100, 7'h76, 4);
    present(3'b001, 7'h7C, 4);
    present(3'b010, 7'h00, 4);
    checkResult("hexB", 1'b1, 4'hB, 1'b0, 1'b0);
    handshake();

    // Decimal 15, then valid must drop after one ready cycle.
    present(3'b010, 7'h06, 4);
    present(3'b001, 7'h6D, 4);
    present(3'b100, 7'h5E, 4);
    checkResult("dec15", 1'b1, 4'hF, 1'b1, 1'b0);
    handshake();
    checkOutput("dec15_drop", {7'b0, bus.valid}, 8'h00);

    // Decimal 16 is out of range.
    present(3'b010, 7'h06, 4);
    present(3'b001, 7'h7D, 4);
    present(3'b100, 7'h5E, 4);
    checkResult("dec16", 1'b1, 4'h0, 1'b1, 1'b1);
    handshake();

    // Unstable LSB and multi-hot strobe never capture.
    present(3'b001, 7'h3F, 3);
    present(3'b001, 7'h06, 1);
    present(3'b011, 7'h3F, 10);
    present(3'b100, 7'h76, 4);
    present(3'b010, 7'h00, 4);
    checkOutput("noCapture_valid", {7'b0, bus.valid}, 8'h00);
    present(3'b001, 7'h3F, 4);
    checkResult("lateLsb", 1'b1, 4'h0, 1'b0, 1'b0);
    handshake();

    // Result held under back-pressure while the bus keeps moving.
    present(3'b100, 7'h76, 4);
    present(3'b010, 7'h00, 4);
    present(3'b001, 7'h66, 4);
    for (int i = 0; i < 10; i++)
      applyStimulus(3'b001 << (i % 3), 7'($urandom), 1'b0, 1'b0);
    checkResult("held", 1'b1, 4'h4, 1'b0, 1'b0);
    handshake();
    checkOutput("held_drop", {7'b0, bus.valid}, 8'h00);
    present(3'b100, 7'h5E, 4);
    present(3'b010, 7'h00, 4);
    present(3'b001, 7'h6F, 4);
    checkResult("rescan", 1'b1, 4'h9, 1'b1, 1'b0);
    handshake();

    // Reset mid-scan discards partial captures.
    present(3'b001, 7'h3F, 4);
    present(3'b010, 7'h00, 4);
    applyStimulus(3'b000, 7'h00, 1'b0, 1'b1);
    checkResult("midReset", 1'b0, 4'h0, 1'b0, 1'b0);
    present(3'b100, 7'h76, 6);
    checkOutput("midReset_valid", {7'b0, bus.valid}, 8'h00);

    // Randomized traffic, including patterns held across the handshake.
    for (int n = 0; n < 400; n++) begin
      sel = ($urandom_range(0, 9) == 0) ? 3'($urandom) : (3'b001 << $urandom_range(0, 2));
      seg = randGlyph(sel);
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++)
        applyStimulus(sel, seg, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
